// File: rtl/audio_stream_pkg.sv
// rtl/audio_stream_pkg.sv - audio chunk layout shared by the packing and unstacking stages
package audio_stream_pkg;
   localparam int AUDIO_W         = 16;
   localparam int WORDS_PER_CHUNK = 8;
   localparam int CHUNK_W         = AUDIO_W * WORDS_PER_CHUNK;
endpackage

// File: rtl/unstacker.sv
// rtl/unstacker.sv - serializes 128-bit audio chunks into 16-bit samples, LS word first
module unstacker #(
   parameter int DATA_WIDTH      = audio_stream_pkg::AUDIO_W,
   parameter int WORDS_PER_CHUNK = audio_stream_pkg::WORDS_PER_CHUNK
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic                                  audio_chunk_tvalid,
   output logic                                  audio_chunk_tready,
   input  logic [DATA_WIDTH*WORDS_PER_CHUNK-1:0] audio_chunk_tdata,
   input  logic                                  audio_chunk_tlast,
   output logic                                  audio_tvalid,
   input  logic                                  audio_tready,
   output logic [DATA_WIDTH-1:0]                 audio_tdata,
   output logic                                  audio_tlast
);
   localparam int CHUNK_W = DATA_WIDTH * WORDS_PER_CHUNK;
   localparam int CNT_W   = $clog2(WORDS_PER_CHUNK);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_CHUNK - 1);

   logic [CHUNK_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               chunk_last_q, chunk_last_d;
   logic               tvalid_q, tvalid_d;
   logic               on_last_word;
   logic               accept_in, accept_out;

   assign on_last_word       = (count_q == LAST_IDX);
   assign audio_chunk_tready = !tvalid_q || (on_last_word && audio_tready);
   assign accept_in          = audio_chunk_tvalid && audio_chunk_tready;
   assign accept_out         = tvalid_q && audio_tready;

   assign audio_tvalid = tvalid_q;
   assign audio_tdata  = hold_q[DATA_WIDTH-1:0];
   assign audio_tlast  = tvalid_q && chunk_last_q && on_last_word;

   always_comb begin
      hold_d       = hold_q;
      count_d      = count_q;
      chunk_last_d = chunk_last_q;
      tvalid_d     = tvalid_q;
      // A load can only coincide with the last-word handshake, so it wins without a bubble.
      if (accept_in) begin
         hold_d       = audio_chunk_tdata;
         chunk_last_d = audio_chunk_tlast;
         count_d      = '0;
         tvalid_d     = 1'b1;
      end else if (accept_out) begin
         hold_d = hold_q >> DATA_WIDTH;
         if (on_last_word) begin
            count_d  = '0;
            tvalid_d = 1'b0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hold_q       <= '0;
         count_q      <= '0;
         chunk_last_q <= 1'b0;
         tvalid_q     <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         count_q      <= count_d;
         chunk_last_q <= chunk_last_d;
         tvalid_q     <= tvalid_d;
      end
   end
endmodule

// File: tb/tb_unstacker.sv
// tb/tb_unstacker.sv - randomized bench for unstacker against a sample-queue reference model
module tb_unstacker;
   localparam int DW = 16;
   localparam int NW = 8;
   localparam int CW = DW * NW;

   typedef struct {
      logic [CW-1:0] data;
      logic          last;
   } chunk_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } sample_t;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          audio_chunk_tvalid = 1'b0;
   logic          audio_chunk_tready;
   logic [CW-1:0] audio_chunk_tdata = '0;
   logic          audio_chunk_tlast = 1'b0;
   logic          audio_tvalid;
   logic          audio_tready = 1'b0;
   logic [DW-1:0] audio_tdata;
   logic          audio_tlast;

   int checks   = 0;
   int failures = 0;
   int popped   = 0;
   chunk_t  in_q[$];
   sample_t exp_q[$];

   unstacker dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .audio_chunk_tvalid (audio_chunk_tvalid),
      .audio_chunk_tready (audio_chunk_tready),
      .audio_chunk_tdata  (audio_chunk_tdata),
      .audio_chunk_tlast  (audio_chunk_tlast),
      .audio_tvalid       (audio_tvalid),
      .audio_tready       (audio_tready),
      .audio_tdata        (audio_tdata),
      .audio_tlast        (audio_tlast)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic add_chunk(input logic [CW-1:0] data, input logic last);
      chunk_t c;
      c.data = data;
      c.last = last;
      in_q.push_back(c);
   endtask

   // One clock of traffic; the model is a plain list of samples still owed downstream.
   task automatic step(input int vpct, input int rpct);
      logic cv, ordy, exp_valid, exp_rdy;
      sample_t s;
      @(negedge clk_in);
      cv   = (in_q.size() > 0) && ($urandom_range(99) < vpct);
      ordy = ($urandom_range(99) < rpct);
      audio_chunk_tvalid = cv;
      audio_chunk_tdata  = cv ? in_q[0].data : {$urandom, $urandom, $urandom, $urandom};
      audio_chunk_tlast  = cv ? in_q[0].last : 1'($urandom_range(1));
      audio_tready       = ordy;
      #1;
      exp_valid = (exp_q.size() > 0);
      exp_rdy   = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
      chk("audio_tvalid", 32'(audio_tvalid), 32'(exp_valid));
      chk("audio_chunk_tready", 32'(audio_chunk_tready), 32'(exp_rdy));
      if (exp_valid) begin
         chk("audio_tdata", 32'(audio_tdata), 32'(exp_q[0].d));
         chk("audio_tlast", 32'(audio_tlast), 32'(exp_q[0].l));
      end else begin
         chk("audio_tlast_idle", 32'(audio_tlast), 32'd0);
      end
      @(posedge clk_in);
      if (exp_valid && ordy) begin
         void'(exp_q.pop_front());
         popped++;
      end
      if (cv && exp_rdy) begin
         for (int i = 0; i < NW; i++) begin
            s.d = in_q[0].data[i*DW +: DW];
            s.l = in_q[0].last && (i == NW - 1);
            exp_q.push_back(s);
         end
         void'(in_q.pop_front());
      end
   endtask

   task automatic run(input int n, input int vpct, input int rpct);
      for (int i = 0; i < n; i++) step(vpct, rpct);
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      audio_chunk_tvalid = 1'b0;
      audio_tready = 1'($urandom_range(1));
      @(posedge clk_in);
      exp_q.delete();
      in_q.delete();
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic drained(input string tag);
      chk(tag, 32'(in_q.size() + exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [CW-1:0] c;
      // reset state
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("rst_tvalid", 32'(audio_tvalid), 32'd0);
      chk("rst_tdata", 32'(audio_tdata), 32'd0);
      chk("rst_tlast", 32'(audio_tlast), 32'd0);
      chk("rst_chunk_tready", 32'(audio_chunk_tready), 32'd1);

      // single incrementing chunk with tlast, full-rate downstream
      for (int i = 0; i < NW; i++) c[i*DW +: DW] = 16'(i);
      add_chunk(c, 1'b1);
      run(12, 100, 100);
      drained("single_chunk_drained");

      // two back-to-back chunks, valid held high
      add_chunk({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      add_chunk({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      run(20, 100, 100);
      drained("b2b_drained");

      // chunk without tlast
      add_chunk({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      run(12, 100, 100);
      drained("no_tlast_drained");

      // four chunks under ~50% downstream and upstream duty
      for (int k = 0; k < 4; k++) add_chunk({$urandom, $urandom, $urandom, $urandom}, k == 3);
      run(200, 50, 50);
      run(20, 100, 100);
      drained("random_ready_drained");

      // reset after three samples of chunk A, then chunk B starts at its sample 0
      add_chunk({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      popped = 0;
      for (int i = 0; i < 100 && popped < 3; i++) step(100, 60);
      chk("reset_mid_reached", 32'(popped), 32'd3);
      do_reset();
      #1;
      chk("post_reset_tvalid", 32'(audio_tvalid), 32'd0);
      chk("post_reset_chunk_tready", 32'(audio_chunk_tready), 32'd1);
      add_chunk({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      run(12, 100, 100);
      drained("after_reset_drained");

      // loopback: 64 incrementing samples packed eight per chunk, tlast on sample 63
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NW; i++) c[i*DW +: DW] = 16'(k * NW + i);
         add_chunk(c, k == 7);
      end
      run(150, 80, 70);
      run(20, 100, 100);
      drained("loopback_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
